mode_ctrl_cgrundey: RTL
=======================

// Module: mode_ctrl_cgrundey
// PURPOSE
//  Sequencer for the display-mode path. Debounces the raw mode push-button and toggles
//  the output mode: 0 = binary ('b' symbol), 1 = BCD ('d' symbol). On each toggle it
//  requests one conversion from the downstream BCD/binary converter and waits for
//  completion. It then blinks the mode symbol digit to acknowledge the change.
//  Sits between board KEY input and the symbol driver / converter on the HEX path.
// PARAMETERS
//  DEBOUNCE_CYCLES  500000    stable-level cycles before the debounced key changes (10 ms @ 50 MHz)
//  BLINK_CYCLES     12500000  cycles per blink phase, blank or shown (0.25 s @ 50 MHz)
//  BLINK_COUNT      3         number of blank+show pairs after a mode change, >=1
//  CONV_TIMEOUT     1024      max cycles to wait for conv_done before giving up
// PORTS
//  clk           in   1  system clock; the only clock
//  reset_n       in   1  asynchronous, active-low reset
//  key_n         in   1  raw mode push-button, active-low, asynchronous to clk
//  conv_done     in   1  converter completion pulse, >=1 cycle high
//  select        out  1  current mode to symbol driver/converter; 0 = binary, 1 = BCD
//  conv_start    out  1  one-cycle conversion request pulse
//  symbol_blank  out  1  1 = blank the symbol digit (blink phase)
//  busy          out  1  1 while the FSM is not in IDLE
//  conv_err      out  1  sticky; set on conversion timeout, cleared by the next accepted press
// BEHAVIOUR
//  Reset (async, reset_n=0): select=0, conv_start=0, symbol_blank=0, busy=0, conv_err=0,
//   FSM=IDLE, sync flops=1, debounced key=1 (released), all counters=0.
//  Input conditioning:
//   - key_n passes a 2-FF synchroniser.
//   - The debounced level follows the synchronised level only after it differs from the
//     debounced level for DEBOUNCE_CYCLES consecutive cycles.
//   - Any bounce restarts the count.
//   - A press event is a debounced 1->0 transition, one cycle wide. Release is ignored.
//  FSM: IDLE -> CONV -> BLINK -> IDLE. busy = (state != IDLE).
//   IDLE:  on a press event, on the next edge:
//          - select <= ~select; conv_err <= 0; conv_start <= 1 for exactly one cycle;
//          - state <= CONV; timeout counter <= 0.
//   CONV:  conv_done is sampled from the cycle after conv_start onward.
//          - conv_done=1: state <= BLINK.
//          - CONV_TIMEOUT cycles with no conv_done: conv_err <= 1; state <= BLINK.
//          - If conv_done and timeout expiry coincide, the done wins (no error).
//   BLINK: 2*BLINK_COUNT phases of BLINK_CYCLES each.
//          - symbol_blank=1 in the first phase, then alternates.
//          - After the last phase (shown, blank=0): state <= IDLE.
//  Press events in CONV or BLINK are dropped, with no queueing. A held key produces one event.
//  conv_done in IDLE or BLINK is ignored.
//  Latency: debounced press -> select/conv_start change = 1 cycle.
//           Total raw key change -> select = 2 (sync) + DEBOUNCE_CYCLES + 1 cycles.
//  Counters are sized $clog2(param+1). Terminal values compare with ==. Counters never wrap.
//  Reset mid-sequence aborts immediately to reset values. select returns to binary.
// STRUCTURE
//  Shared include mode_ctrl_defs_cgrundey.vh:
//   - state encodings (IDLE, CONV, BLINK)
//   - MODE_BIN=1'b0, MODE_BCD=1'b1, also used by the symbol driver and converter.
//  One sub-module: debounce_cgrundey (synchroniser + debounce counter + falling-edge
//   pulse, params DEBOUNCE_CYCLES). FSM, timeout and blink counters stay in this module.
// TESTING (bench params: DEBOUNCE_CYCLES=4, BLINK_CYCLES=3, BLINK_COUNT=2, CONV_TIMEOUT=8)
//  1 Reset: assert reset_n=0 mid-BLINK -> all outputs 0 at once; after release, busy=0, select=0.
//  2 Clean press: key_n low 10 cycles, conv_done 2 cycles after conv_start ->
//    - select 0->1 and single conv_start at sync+4+1 cycles;
//    - blank pattern 1,0,1,0 at 3 cycles each, then busy=0.
//  3 Bounce: key_n toggles every 2 cycles for 20 cycles, then stays high -> no event; select unchanged.
//  4 Timeout: press, conv_done held 0 -> conv_err=1 eight cycles after conv_start, BLINK runs;
//    next press clears conv_err.
//  5 Busy drop: second press during BLINK -> ignored; exactly one select toggle and one conv_start.
//  6 Coincidence: conv_done on the 8th CONV cycle -> conv_err stays 0. Two full presses -> select returns to 0.

Source files
------------

// File: rtl/mode_ctrl_cgrundey_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mode_ctrl_cgrundey_pkg
// Brief    : Shared definitions for the display-mode path: sequencer state
//            encodings and the binary/BCD mode values that the symbol driver
//            and converter also use.
// Revision : 1.0 - initial release
// ============================================================================
package mode_ctrl_cgrundey_pkg;

  // Sequencer states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CONV  = 2'd1,
    ST_BLINK = 2'd2
  } mode_state_e;

  // Display mode values carried on select
  localparam logic MODE_BIN = 1'b0;
  localparam logic MODE_BCD = 1'b1;

  // Flip between binary and BCD display
  function automatic logic next_mode(input logic cur);
    return (cur == MODE_BIN) ? MODE_BCD : MODE_BIN;
  endfunction

endpackage : mode_ctrl_cgrundey_pkg
`default_nettype wire

// File: rtl/mode_ctrl_cgrundey_debounce.sv
`default_nettype none
// ============================================================================
// Module   : debounce_cgrundey
// Brief    : Two-flop synchroniser, stable-level debounce counter and a
//            one-cycle pulse on each debounced press (1->0) of an active-low
//            push-button.
// Revision : 1.0 - initial release
// ============================================================================
module debounce_cgrundey #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic key_n,
  output logic press
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             deb_q, deb_d;
  logic             deb_dly_q, deb_dly_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Synchronise the key and let the debounced level follow only after a
  // full run of consecutive differing samples; any agreement restarts it.
  always_comb begin
    sync1_d   = key_n;
    sync2_d   = sync1_q;
    deb_d     = deb_q;
    deb_dly_d = deb_q;
    cnt_d     = cnt_q;
    if (sync2_q != deb_q) begin
      if (cnt_q == CNT_LAST) begin
        deb_d = sync2_q;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_d = '0;
    end
  end

  // State registers; the key idles released (high) out of reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      deb_q     <= 1'b1;
      deb_dly_q <= 1'b1;
      cnt_q     <= '0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      deb_q     <= deb_d;
      deb_dly_q <= deb_dly_d;
      cnt_q     <= cnt_d;
    end
  end

  // Press is the registered falling edge of the debounced level
  assign press = deb_dly_q & ~deb_q;

endmodule : debounce_cgrundey
`default_nettype wire

// File: rtl/mode_ctrl_cgrundey.sv
`default_nettype none
// ============================================================================
// Module   : mode_ctrl_cgrundey
// Brief    : Display-mode sequencer. A debounced press toggles binary/BCD
//            mode, fires one converter request, waits for completion (with
//            timeout) and then blinks the mode symbol digit.
// Revision : 1.0 - initial release
// ============================================================================
module mode_ctrl_cgrundey
  import mode_ctrl_cgrundey_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int BLINK_CYCLES    = 12500000,
  parameter int BLINK_COUNT     = 3,
  parameter int CONV_TIMEOUT    = 1024
) (
  input  logic clk,
  input  logic reset_n,
  input  logic key_n,
  input  logic conv_done,
  output logic select,
  output logic conv_start,
  output logic symbol_blank,
  output logic busy,
  output logic conv_err
);

  localparam int TMO_W = $clog2(CONV_TIMEOUT + 1);
  localparam int CYC_W = $clog2(BLINK_CYCLES + 1);
  localparam int PH_W  = $clog2(2 * BLINK_COUNT + 1);

  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(CONV_TIMEOUT - 1);
  localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(BLINK_CYCLES - 1);
  localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(2 * BLINK_COUNT - 1);

  logic press;

  mode_state_e      state_q, state_d;
  logic             select_q, select_d;
  logic             conv_start_q, conv_start_d;
  logic             blank_q, blank_d;
  logic             err_q, err_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [CYC_W-1:0] cyc_q, cyc_d;
  logic [PH_W-1:0]  ph_q, ph_d;

  debounce_cgrundey #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk    (clk),
    .reset_n(reset_n),
    .key_n  (key_n),
    .press  (press)
  );

  // Next-state and registered-output logic of the IDLE/CONV/BLINK sequencer
  always_comb begin
    state_d      = state_q;
    select_d     = select_q;
    conv_start_d = 1'b0;
    blank_d      = blank_q;
    err_d        = err_q;
    tmo_d        = tmo_q;
    cyc_d        = cyc_q;
    ph_d         = ph_q;
    unique case (state_q)
      ST_IDLE: begin
        if (press) begin
          select_d     = next_mode(select_q);
          err_d        = 1'b0;
          conv_start_d = 1'b1;
          tmo_d        = '0;
          state_d      = ST_CONV;
        end
      end
      ST_CONV: begin
        // The request cycle itself never counts as completion; done beats
        // a timeout that expires on the same cycle.
        if (conv_done && !conv_start_q) begin
          state_d = ST_BLINK;
          blank_d = 1'b1;
          cyc_d   = '0;
          ph_d    = '0;
        end else if (tmo_q == TMO_LAST) begin
          err_d   = 1'b1;
          state_d = ST_BLINK;
          blank_d = 1'b1;
          cyc_d   = '0;
          ph_d    = '0;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      ST_BLINK: begin
        if (cyc_q == CYC_LAST) begin
          cyc_d = '0;
          if (ph_q == PH_LAST) begin
            blank_d = 1'b0;
            state_d = ST_IDLE;
          end else begin
            ph_d    = ph_q + PH_W'(1);
            blank_d = ~blank_q;
          end
        end else begin
          cyc_d = cyc_q + CYC_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Sequencer registers; reset aborts any sequence and returns to binary
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      select_q     <= MODE_BIN;
      conv_start_q <= 1'b0;
      blank_q      <= 1'b0;
      err_q        <= 1'b0;
      tmo_q        <= '0;
      cyc_q        <= '0;
      ph_q         <= '0;
    end else begin
      state_q      <= state_d;
      select_q     <= select_d;
      conv_start_q <= conv_start_d;
      blank_q      <= blank_d;
      err_q        <= err_d;
      tmo_q        <= tmo_d;
      cyc_q        <= cyc_d;
      ph_q         <= ph_d;
    end
  end

  assign select       = select_q;
  assign conv_start   = conv_start_q;
  assign symbol_blank = blank_q;
  assign conv_err     = err_q;
  assign busy         = (state_q != ST_IDLE);

endmodule : mode_ctrl_cgrundey
`default_nettype wire
